// File: rtl/host_interface_burst.sv
// rtl/host_interface_burst.sv - GPIF-style host interface: address loads, burst register writes/reads, read timeout.
// Host pins are registered once and rdwr_b rising edges are registered again before any action is taken.
module host_interface_burst #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int EP_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  if_clock,
  input  logic                  reset,
  input  logic [2:0]            ctl,
  input  logic [3:0]            state,
  output logic                  rdy,
  output logic                  out,
  inout  logic [DATA_WIDTH-1:0] data,
  output logic [EP_WIDTH-1:0]   diEpAddr,
  output logic [ADDR_WIDTH-1:0] diRegAddr,
  output logic [DATA_WIDTH-1:0] diRegDataIn,
  input  logic [DATA_WIDTH-1:0] diRegDataOut,
  output logic                  diWrite,
  output logic                  diRead,
  output logic                  diReset,
  input  logic                  rdwr_ready,
  output logic                  diTimeout
);

  localparam logic [3:0] OP_SETEP     = 4'd1;
  localparam logic [3:0] OP_SETREG    = 4'd2;
  localparam logic [3:0] OP_SETRVAL   = 4'd3;
  localparam logic [3:0] OP_RDDATA    = 4'd4;
  localparam logic [3:0] OP_RESETRVAL = 4'd5;
  localparam logic [3:0] OP_SETMODE   = 4'd6;
  localparam logic [3:0] OP_WRDATA    = 4'd7;

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // RD_ISSUE covers the diRead cycle so rdwr_ready is not looked at during it.
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_WAIT
  } rd_state_t;

  logic [3:0]            sc_q, sc_d, sc_old_q, sc_old_d;
  logic                  rdwr_b_q, rdwr_b_d, rdwr_b_dly_q, rdwr_b_dly_d;
  logic [DATA_WIDTH-1:0] din_q, din_d, din_s_q, din_s_d;
  logic                  strobe_q, strobe_d;
  logic [EP_WIDTH-1:0]   ep_q, ep_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] hi_data_q, hi_data_d;
  logic                  write_q, write_d, read_q, read_d, rst_pulse_q, rst_pulse_d;
  logic                  inc_q, inc_d, mode_q, mode_d, timeout_q, timeout_d;
  logic                  rdy_q, rdy_d, we_q, we_d;
  rd_state_t             rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  unused_ctl;

  assign unused_ctl = ctl[2] ^ ctl[0];

  always_comb begin
    sc_d         = state;
    sc_old_d     = sc_q;
    rdwr_b_d     = ctl[1];
    rdwr_b_dly_d = rdwr_b_q;
    din_d        = data;
    // A rising edge seen while the state code is still settling is dropped.
    strobe_d     = rdwr_b_q & ~rdwr_b_dly_q & (sc_q == sc_old_q);
    din_s_d      = din_q;
    ep_d         = ep_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mode_d       = mode_q;
    timeout_d    = timeout_q;
    rdy_d        = rdy_q;
    we_d         = we_q;
    hi_data_d    = hi_data_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    write_d      = 1'b0;
    read_d       = 1'b0;
    rst_pulse_d  = 1'b0;
    inc_d        = 1'b0;

    if (sc_q != sc_old_q) begin
      rdy_d = 1'b0;
      we_d  = 1'b0;
      rd_d  = RD_IDLE;
      cnt_d = '0;
    end else begin
      if (inc_q && mode_q) begin
        addr_d = addr_q + ADDR_WIDTH'(1);
      end

      if (strobe_q) begin
        rdy_d = 1'b0;
        we_d  = 1'b0;
        case (sc_q)
          OP_SETEP:  ep_d   = din_s_q[EP_WIDTH-1:0];
          OP_SETREG: addr_d = din_s_q[ADDR_WIDTH-1:0];
          OP_SETMODE: mode_d = din_s_q[0];
          OP_SETRVAL, OP_WRDATA: begin
            wdata_d = din_s_q;
            write_d = 1'b1;
            inc_d   = 1'b1;
          end
          OP_RESETRVAL: begin
            rst_pulse_d = 1'b1;
            timeout_d   = 1'b0;
          end
          OP_RDDATA: begin
            if (rd_q == RD_IDLE) begin
              read_d = 1'b1;
              cnt_d  = '0;
              rd_d   = RD_ISSUE;
            end
          end
          default: ;
        endcase
      end

      case (rd_q)
        RD_ISSUE: begin
          rd_d  = RD_WAIT;
          cnt_d = '0;
        end
        RD_WAIT: begin
          if (rdwr_ready) begin
            hi_data_d = diRegDataOut;
            we_d      = 1'b1;
            rdy_d     = 1'b1;
            rd_d      = RD_IDLE;
            if (mode_q) addr_d = addr_q + ADDR_WIDTH'(1);
          end else if (cnt_q == CNT_LAST) begin
            hi_data_d = {DATA_WIDTH{1'b1}};
            we_d      = 1'b1;
            rdy_d     = 1'b1;
            timeout_d = 1'b1;
            rd_d      = RD_IDLE;
            if (mode_q) addr_d = addr_q + ADDR_WIDTH'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge if_clock) begin
    if (reset) begin
      sc_q         <= '0;
      sc_old_q     <= '0;
      // Held high through reset so a strobe pin left asserted is not seen as a new edge.
      rdwr_b_q     <= 1'b1;
      rdwr_b_dly_q <= 1'b1;
      din_q        <= '0;
      din_s_q      <= '0;
      strobe_q     <= 1'b0;
      ep_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      hi_data_q    <= '0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      rst_pulse_q  <= 1'b0;
      inc_q        <= 1'b0;
      mode_q       <= 1'b0;
      timeout_q    <= 1'b0;
      rdy_q        <= 1'b0;
      we_q         <= 1'b0;
      rd_q         <= RD_IDLE;
      cnt_q        <= '0;
    end else begin
      sc_q         <= sc_d;
      sc_old_q     <= sc_old_d;
      rdwr_b_q     <= rdwr_b_d;
      rdwr_b_dly_q <= rdwr_b_dly_d;
      din_q        <= din_d;
      din_s_q      <= din_s_d;
      strobe_q     <= strobe_d;
      ep_q         <= ep_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      hi_data_q    <= hi_data_d;
      write_q      <= write_d;
      read_q       <= read_d;
      rst_pulse_q  <= rst_pulse_d;
      inc_q        <= inc_d;
      mode_q       <= mode_d;
      timeout_q    <= timeout_d;
      rdy_q        <= rdy_d;
      we_q         <= we_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
    end
  end

  assign data        = we_q ? hi_data_q : {DATA_WIDTH{1'bz}};
  assign rdy         = rdy_q;
  assign out         = 1'b0;
  assign diEpAddr    = ep_q;
  assign diRegAddr   = addr_q;
  assign diRegDataIn = wdata_q;
  assign diWrite     = write_q;
  assign diRead      = read_q;
  assign diReset     = rst_pulse_q;
  assign diTimeout   = timeout_q;

endmodule
